// File: rtl/frame_ram_arbiter.sv
// Shares one single-port frame RAM between the VGA reader (priority) and the
// serial pixel writer; a read-run limit keeps a pending write from starving.
module frame_ram_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 129600,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RD_LATENCY = 1,
    parameter int MAX_RD_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              addr_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int               RUN_W   = $clog2(MAX_RD_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);
    localparam logic [2:0]       LAT     = 3'(RD_LATENCY);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DONE} state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  rd_run_q, rd_run_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_ack_q, wr_ack_d;
    logic              addr_err_q, addr_err_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic rd_oob, wr_oob, rd_win;

    assign rd_oob = {1'b0, rd_addr} >= DEPTH_L;
    assign wr_oob = {1'b0, wr_addr} >= DEPTH_L;
    assign rd_win = rd_req && (!wr_req || rd_run_q < RUN_MAX);

    always_comb begin
        state_d     = state_q;
        rd_run_d    = rd_run_q;
        cnt_d       = cnt_q;
        rd_ack_d    = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        wr_ack_d    = 1'b0;
        addr_err_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (rd_win) begin
                    rd_ack_d = 1'b1;
                    // rd_win guarantees rd_run_q < RUN_MAX when wr_req is high
                    rd_run_d = wr_req ? rd_run_q + RUN_W'(1) : '0;
                    if (rd_oob) begin
                        addr_err_d = 1'b1;
                        state_d    = WR_DONE;
                    end else begin
                        ram_addr_d = rd_addr;
                        cnt_d      = '0;
                        state_d    = RD_WAIT;
                    end
                end else if (wr_req) begin
                    wr_ack_d = 1'b1;
                    rd_run_d = '0;
                    state_d  = WR_DONE;
                    if (wr_oob) begin
                        addr_err_d = 1'b1;
                    end else begin
                        ram_addr_d  = wr_addr;
                        ram_wdata_d = wr_data;
                        ram_we_d    = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAT) begin
                    rd_data_d  = ram_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rd_run_q    <= '0;
            cnt_q       <= '0;
            rd_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            wr_ack_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_run_q    <= rd_run_d;
            cnt_q       <= cnt_d;
            rd_ack_q    <= rd_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            wr_ack_q    <= wr_ack_d;
            addr_err_q  <= addr_err_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign rd_ack    = rd_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr_ack    = wr_ack_q;
    assign addr_err  = addr_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Randomized bench for frame_ram_arbiter: transaction-level model of grants,
// memory contents and read latency, plus a RD_LATENCY=3 instance.
module tb_frame_ram_arbiter;
  localparam int DEPTH   = 129600;
  localparam int MAX_RUN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_req, wr_req, rd_ack, rd_valid, wr_ack, addr_err, ram_we;
  logic [16:0] rd_addr, wr_addr, ram_addr;
  logic [31:0] wr_data, rd_data, ram_wdata, ram_rdata;

  logic        rd_req3, rd_ack3, rd_valid3, wr_ack3, addr_err3, ram_we3;
  logic [16:0] rd_addr3, ram_addr3;
  logic [31:0] rd_data3, ram_wdata3, ram_rdata3;

  frame_ram_arbiter u_dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .addr_err(addr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  frame_ram_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .rd_req(rd_req3), .rd_addr(rd_addr3), .rd_ack(rd_ack3), .rd_valid(rd_valid3), .rd_data(rd_data3),
    .wr_req(1'b0), .wr_addr(17'd0), .wr_data(32'd0), .wr_ack(wr_ack3), .addr_err(addr_err3),
    .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  function automatic logic [31:0] init_word(logic [16:0] a);
    if (a == 17'h00010) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  // RAM models: latency 1 with writes overlaying the preload, latency 3 read-only
  bit          wr_flag [0:DEPTH-1];
  logic [31:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    ram_rdata <= wr_flag[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      wr_flag[ram_addr] <= 1'b1;
    end
  end

  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1         <= init_word(ram_addr3);
    p2         <= p1;
    ram_rdata3 <= p2;
  end

  int we_seen, rv_seen;
  always @(posedge clk) begin
    if (ram_we)   we_seen <= we_seen + 1;
    if (rd_valid) rv_seen <= rv_seen + 1;
  end

  // reference state
  logic [31:0] ref_mem [int];
  int run, gap, exp_we, exp_rv;
  int n_chk, n_err;

  function automatic logic [31:0] ref_rd(logic [16:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 17'(DEPTH - 1 - int'($urandom_range(0, 3)));
    return 17'($urandom_range(0, 15));
  endfunction

  // one grant: present any new requests, predict the winner, check the handshake
  task automatic round(input bit want_rd, input bit want_wr);
    bit          exp_rd;
    logic [16:0] a;
    if (want_rd && !rd_req) begin rd_req = 1'b1; rd_addr = pick_addr(); end
    if (want_wr && !wr_req) begin wr_req = 1'b1; wr_addr = pick_addr(); wr_data = $urandom; end
    if (!rd_req && !wr_req) begin step(); gap = 1; return; end
    exp_rd = rd_req && (!wr_req || run < MAX_RUN);
    repeat (gap - 1) begin
      step();
      chk("busy_quiet", {29'd0, rd_ack, wr_ack, ram_we}, 32'd0);
    end
    step();
    chk("rd_ack", 32'(rd_ack), 32'(exp_rd));
    chk("wr_ack", 32'(wr_ack), 32'(!exp_rd));
    chk("addr_err", 32'(addr_err), 32'd0);
    if (exp_rd) begin
      run = wr_req ? ((run < MAX_RUN) ? run + 1 : run) : 0;
      chk("rd_ram_addr", 32'(ram_addr), 32'(rd_addr));
      chk("rd_ram_we", 32'(ram_we), 32'd0);
      a = rd_addr;
      rd_req = 1'b0;
      step();
      chk("rd_valid_early", 32'(rd_valid), 32'd0);
      step();
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", rd_data, ref_rd(a));
      exp_rv++;
      gap = 1;
    end else begin
      chk("wr_ram_we", 32'(ram_we), 32'd1);
      chk("wr_ram_addr", 32'(ram_addr), 32'(wr_addr));
      chk("wr_ram_wdata", ram_wdata, wr_data);
      ref_mem[int'(wr_addr)] = wr_data;
      exp_we++;
      run = 0;
      wr_req = 1'b0;
      gap = 2;
    end
  endtask

  task automatic reject(input bit is_rd, input logic [16:0] a);
    logic [16:0] held;
    held = ram_addr;
    if (is_rd) begin rd_req = 1'b1; rd_addr = a; end
    else begin wr_req = 1'b1; wr_addr = a; wr_data = $urandom; end
    repeat (gap - 1) step();
    step();
    chk(is_rd ? "rej_rd_ack" : "rej_wr_ack", 32'(is_rd ? rd_ack : wr_ack), 32'd1);
    chk("rej_addr_err", 32'(addr_err), 32'd1);
    chk("rej_ram_we", 32'(ram_we), 32'd0);
    chk("rej_ram_addr", 32'(ram_addr), 32'(held));
    rd_req = 1'b0;
    wr_req = 1'b0;
    run = 0;
    repeat (2) begin
      step();
      chk("rej_quiet", {28'd0, rd_valid, rd_ack, wr_ack, addr_err}, 32'd0);
    end
    gap = 1;
  endtask

  logic [9:0] seq;
  int         prd, pwr;
  logic [16:0] a5;

  initial begin
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    rd_req3 = 1'b0; rd_addr3 = '0;
    run = 0; gap = 1; exp_we = 0; exp_rv = 0; n_chk = 0; n_err = 0;
    #3;
    chk("rst_flags", {26'd0, rd_ack, rd_valid, wr_ack, addr_err, ram_we, 1'b0}, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    step(); step();
    rst = 1'b1;

    // read of a preloaded word, then write at the last address and read it back
    rd_req = 1'b1; rd_addr = 17'h00010;
    round(1'b0, 1'b0);
    chk("t1_rd_data", rd_data, 32'hDEADBEEF);
    wr_req = 1'b1; wr_addr = 17'h1FA3F; wr_data = 32'h12345678;
    round(1'b0, 1'b0);
    rd_req = 1'b1; rd_addr = 17'h1FA3F;
    round(1'b0, 1'b0);
    chk("t2_readback", rd_data, 32'h12345678);

    // both requesters held: reads are cut off after MAX_RUN while a write waits
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      round(1'b1, 1'b1);
      seq = {seq[8:0], wr_ack};
    end
    chk("t3_grant_seq", 32'(seq), 32'h021);
    round(1'b0, 1'b0);

    // out-of-range addresses
    reject(1'b1, 17'd129600);
    reject(1'b0, 17'h1FFFF);

    // reset while a read is waiting for RAM data
    a5 = 17'h00007;
    rd_req = 1'b1; rd_addr = a5;
    step();
    chk("t5_rd_ack", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_flags", {27'd0, rd_ack, rd_valid, wr_ack, addr_err, ram_we}, 32'd0);
    chk("t5_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("t5_rst_ram_wdata", ram_wdata, 32'd0);
    chk("t5_rst_rd_data", rd_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run = 0;
    repeat (3) begin
      step();
      chk("t5_no_valid", 32'(rd_valid), 32'd0);
    end
    gap = 1;
    rd_req = 1'b1; rd_addr = a5;
    round(1'b0, 1'b0);

    // RD_LATENCY=3 instance: rd_valid four cycles after rd_ack
    rd_req3 = 1'b1; rd_addr3 = 17'h00123;
    step();
    chk("t6_rd_ack", 32'(rd_ack3), 32'd1);
    rd_req3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_valid_early", 32'(rd_valid3), 32'd0);
    end
    step();
    chk("t6_rd_valid", 32'(rd_valid3), 32'd1);
    chk("t6_rd_data", rd_data3, init_word(17'h00123));
    chk("t6_no_write", {29'd0, wr_ack3, addr_err3, ram_we3}, 32'd0);
    chk("t6_wdata", ram_wdata3, 32'd0);

    // random traffic in three request mixes
    for (int blk = 0; blk < 6; blk++) begin
      case (blk % 3)
        0:       begin prd = 90; pwr = 90; end
        1:       begin prd = 80; pwr = 10; end
        default: begin prd = 40; pwr = 50; end
      endcase
      for (int i = 0; i < 50; i++)
        round(int'($urandom_range(0, 99)) < prd, int'($urandom_range(0, 99)) < pwr);
    end
    while (rd_req || wr_req) round(1'b0, 1'b0);
    step();

    chk("we_pulses", 32'(we_seen), 32'(exp_we));
    chk("rd_valid_pulses", 32'(rv_seen), 32'(exp_rv));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
